// File: rtl/debam_mult_pipe.sv
// Pipelined DeBAM approximate / exact unsigned multiplier with valid-ready flow and tag sideband.
// Optional saturating inexact-result counter enabled by defining DEBAM_ERRCNT_EN.

module debam_pair #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH+1:0] pp
);
  logic [WIDTH+1:0] b2, b3, ex;
  logic [WIDTH-1:0] ap;

  always_comb begin
    b2 = {1'b0, b, 1'b0};
    b3 = b2 + {2'b00, b};
    ex = '0;
    ap = '0;
    case (sel)
      2'b01: begin ex = {2'b00, b}; ap = b;                      end
      2'b10: begin ex = b2;         ap = b2[WIDTH-1:0];          end
      2'b11: begin ex = b3;         ap = b2[WIDTH-1:0] | b;      end
      default: ;
    endcase
    // approximate terms drop the carries out of the top bit instead of rippling them
    pp = mode ? {2'b00, ap} : ex;
  end
endmodule

module debam_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_q,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_mode,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_cnt
);
  localparam int P      = (WIDTH-2)/2;
  localparam int QW     = 2*WIDTH;
  localparam int STAGES = 3;

  logic adv;
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;

  logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;
  logic             mode0_q, mode0_d;
  logic [TAG_W-1:0] tag0_q, tag0_d;

  logic [P-1:0][WIDTH+1:0] pp_c;
  logic [P-1:0][WIDTH+1:0] pp1_q, pp1_d;
  logic [1:0][WIDTH-1:0]   sgl1_q, sgl1_d;
  logic                    mode1_q, mode1_d;
  logic [TAG_W-1:0]        tag1_q, tag1_d;

  logic [QW-1:0]    psa2_q, psa2_d, psb2_q, psb2_d;
  logic             mode2_q, mode2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic [QW-1:0]    res3_q, res3_d;
  logic             mode3_q, mode3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  // whole pipe moves as one; only a stalled output slot can block it
  assign adv       = !vld_pipe_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_q     = res3_q;
  assign out_tag   = tag3_q;
  assign out_mode  = mode3_q;

  for (genvar i = 0; i < P; i++) begin : g_pair
    debam_pair #(.WIDTH(WIDTH)) u_pair (
      .sel (a0_q[2*i+1:2*i]),
      .b   (b0_q),
      .mode(mode0_q),
      .pp  (pp_c[i])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    a0_d = a0_q;  b0_d = b0_q;  mode0_d = mode0_q;  tag0_d = tag0_q;
    pp1_d = pp1_q;  sgl1_d = sgl1_q;  mode1_d = mode1_q;  tag1_d = tag1_q;
    psa2_d = psa2_q;  psb2_d = psb2_q;  mode2_d = mode2_q;  tag2_d = tag2_q;
    res3_d = res3_q;  mode3_d = mode3_q;  tag3_d = tag3_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};
      a0_d = in_a;  b0_d = in_b;  mode0_d = in_mode;  tag0_d = in_tag;

      pp1_d     = pp_c;
      sgl1_d[0] = a0_q[WIDTH-2] ? b0_q : '0;
      sgl1_d[1] = a0_q[WIDTH-1] ? b0_q : '0;
      mode1_d   = mode0_q;
      tag1_d    = tag0_q;

      psa2_d = '0;
      for (int i = 0; i < P; i++)
        psa2_d = psa2_d + (QW'(pp1_q[i]) << (2*i));
      psb2_d  = (QW'(sgl1_q[0]) << (WIDTH-2)) + (QW'(sgl1_q[1]) << (WIDTH-1));
      mode2_d = mode1_q;
      tag2_d  = tag1_q;

      res3_d  = psa2_q + psb2_q;
      mode3_d = mode2_q;
      tag3_d  = tag2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a0_q <= '0;  b0_q <= '0;  mode0_q <= 1'b0;  tag0_q <= '0;
      pp1_q <= '0;  sgl1_q <= '0;  mode1_q <= 1'b0;  tag1_q <= '0;
      psa2_q <= '0;  psb2_q <= '0;  mode2_q <= 1'b0;  tag2_q <= '0;
      res3_q <= '0;  mode3_q <= 1'b0;  tag3_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a0_q <= a0_d;  b0_q <= b0_d;  mode0_q <= mode0_d;  tag0_q <= tag0_d;
      pp1_q <= pp1_d;  sgl1_q <= sgl1_d;  mode1_q <= mode1_d;  tag1_q <= tag1_d;
      psa2_q <= psa2_d;  psb2_q <= psb2_d;  mode2_q <= mode2_d;  tag2_q <= tag2_d;
      res3_q <= res3_d;  mode3_q <= mode3_d;  tag3_q <= tag3_d;
    end
  end

`ifdef DEBAM_ERRCNT_EN
  logic [P-1:0][WIDTH+1:0] ppx_c;
  logic inx1_q, inx1_d, inx2_q, inx2_d, inx3_q, inx3_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // exact shadow: approx <= exact per term, so any differing pair makes the product inexact
  for (genvar i = 0; i < P; i++) begin : g_shadow
    debam_pair #(.WIDTH(WIDTH)) u_shadow (
      .sel (a0_q[2*i+1:2*i]),
      .b   (b0_q),
      .mode(1'b0),
      .pp  (ppx_c[i])
    );
  end

  always_comb begin
    inx1_d = inx1_q;  inx2_d = inx2_q;  inx3_d = inx3_q;
    if (adv) begin
      inx1_d = mode0_q && (pp_c != ppx_c);
      inx2_d = inx1_q;
      inx3_d = inx2_q;
    end
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (out_valid && out_ready && mode3_q && inx3_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inx1_q <= 1'b0;  inx2_q <= 1'b0;  inx3_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      inx1_q <= inx1_d;  inx2_q <= inx2_d;  inx3_q <= inx3_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif
endmodule

// File: tb/tb_debam_mult_pipe.sv
// Scoreboard bench for debam_mult_pipe at WIDTH=8: directed vectors, streaming, stall, reset, counter.
module tb_debam_mult_pipe;
  localparam int W = 8, TW = 4, CW = 2;
`ifdef DEBAM_ERRCNT_EN
  localparam bit ECNT = 1'b1;
`else
  localparam bit ECNT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic out_valid, out_ready = 1'b1, out_mode, err_clr = 1'b0;
  logic [2*W-1:0] out_q;
  logic [CW-1:0] err_cnt;

  debam_mult_pipe #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .out_mode(out_mode), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] q;
    logic [TW-1:0]  tag;
    logic           m;
    int             cyc;
    bit             lat;
  } exp_t;
  exp_t sb[$];

  int errs = 0, checks = 0, cyc = 0, rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int acc, s, t;
    if (!m) begin
      acc = int'(a) * int'(b);
      return acc[2*W-1:0];
    end
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      s = (int'(a) >> (2*i)) & 3;
      if (s < 2)       t = s * int'(b);
      else if (s == 2) t = (2*int'(b)) % 256;
      else             t = ((2*int'(b)) | int'(b)) % 256;
      acc += t << (2*i);
    end
    acc += (int'(a[6]) * int'(b)) << 6;
    acc += (int'(a[7]) * int'(b)) << 7;
    return acc[2*W-1:0];
  endfunction

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_out: got q=%0h tag=%0h expected no output", out_q, out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_q", out_q, e.q);
        chk("out_tag", out_tag, e.tag);
        chk("out_mode", out_mode, e.m);
        if (e.lat) chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                      input logic [TW-1:0] t, input logic [2*W-1:0] q, input bit lat);
    int n;
    bit done;
    n = 0; done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_tag = t;
    while (!done) begin
      #2;
      if (in_ready) begin
        sb.push_back('{q, t, m, cyc + 1, lat});
        @(posedge clk);
        done = 1;
      end else if (++n > 300) begin
        checks++; errs++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errs++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  logic [W-1:0]   va [10] = '{8'hFF, 8'hFF, 8'h03, 8'h02, 8'h03, 8'h02, 8'h80, 8'h0A, 8'h34, 8'h00};
  logic [W-1:0]   vb [10] = '{8'hFF, 8'hFF, 8'h03, 8'h80, 8'h03, 8'h80, 8'hFF, 8'h81, 8'h10, 8'h5A};
  logic           vm [10] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
  logic [2*W-1:0] vq [10] = '{16'hD42B, 16'hFE01, 16'h0007, 16'h0000, 16'h0009,
                              16'h0100, 16'h7F80, 16'h000A, 16'h0340, 16'h0000};

  initial begin
    logic [2*W-1:0] hq;
    logic [TW-1:0]  ht;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;

    // directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      send(va[i], vb[i], vm[i], TW'(i), vq[i], 1'b1);
      idle();
      drain();
    end

    // back-to-back stream, each must show latency 3
    for (int i = 0; i < 4; i++) send(va[i], vb[i], vm[i], TW'(i + 1), vq[i], 1'b1);
    idle();
    drain();

    // fill the pipe against a stalled output
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(va[i+4], vb[i+4], vm[i+4], TW'(i + 5), vq[i+4], 1'b0);
    idle();
    #2;
    hq = out_q; ht = out_tag;
    chk("stall_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_q", out_q, hq);
      chk("stall_out_tag", out_tag, ht);
    end
    rdy_mode = 0;
    drain();

    // reset with operations in flight
    for (int i = 0; i < 4; i++) send(va[i], vb[i], vm[i], TW'(i + 9), vq[i], 1'b0);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_q", out_q, 0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(8'hFF, 8'hFF, 1'b1, 4'hD, 16'hD42B, 1'b1);
    idle();
    drain();

    // error counter: saturation, clear over increment, exact never counts
    for (int i = 0; i < 5; i++) send(8'hFF, 8'hFF, 1'b1, TW'(i), 16'hD42B, 1'b0);
    idle();
    drain();
    chk("err_cnt_sat", err_cnt, ECNT ? 3 : 0);
    @(negedge clk); err_clr = 1'b1;
    send(8'hFF, 8'hFF, 1'b1, 4'h5, 16'hD42B, 1'b0);
    idle();
    drain();
    chk("err_cnt_clr", err_cnt, 0);
    @(negedge clk); err_clr = 1'b0;
    send(8'hFF, 8'hFF, 1'b0, 4'h6, 16'hFE01, 1'b0);
    send(8'h34, 8'h10, 1'b1, 4'h7, 16'h0340, 1'b0);
    idle();
    drain();
    chk("err_cnt_exact_only", err_cnt, 0);
    send(8'h03, 8'h03, 1'b1, 4'h8, 16'h0007, 1'b0);
    idle();
    drain();
    chk("err_cnt_one", err_cnt, ECNT ? 1 : 0);

    // random operands with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      logic rm;
      ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom_range(0, 1));
      send(ra, rb, rm, TW'($urandom), model(ra, rb, rm), 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
